// File: rtl/multi_channel_loop_agen_if.sv
// Bus bundle for multi_channel_loop_agen: configuration and start from the decoder,
// address tuples with valid/ready toward the scratchpad ports.
interface multi_channel_loop_agen_if #(
    parameter int NUM_LOOPS      = 7,
    parameter int LOG_NUM_LOOPS  = 3,
    parameter int NUM_CH         = 2,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int STRIDE_WIDTH   = 32,
    parameter int NUM_ITER_WIDTH = 16
);
    logic                                       start;
    logic                                       abort;
    logic [LOG_NUM_LOOPS-1:0]                   depth;
    logic [NUM_LOOPS*NUM_ITER_WIDTH-1:0]        num_iter;
    logic [NUM_CH*ADDRESS_WIDTH-1:0]            base;
    logic [NUM_CH*NUM_LOOPS*STRIDE_WIDTH-1:0]   stride;
    logic [NUM_CH*ADDRESS_WIDTH-1:0]            addr_out;
    logic                                       addr_valid;
    logic                                       addr_ready;
    logic                                       addr_last;
    logic                                       busy;
    logic                                       done;
    logic [31:0]                                stall_cnt;

    modport master (
        input  start, abort, depth, num_iter, base, stride, addr_ready,
        output addr_out, addr_valid, addr_last, busy, done, stall_cnt
    );

    modport slave (
        output start, abort, depth, num_iter, base, stride, addr_ready,
        input  addr_out, addr_valid, addr_last, busy, done, stall_cnt
    );
endinterface

// File: rtl/multi_channel_loop_agen.sv
// Multi-channel nested-loop address generator with valid/ready output.
// Optional back-pressure counter: define MULTI_CHANNEL_LOOP_AGEN_STALL_CNT_EN.
module multi_channel_loop_agen #(
    parameter int NUM_LOOPS      = 7,
    parameter int LOG_NUM_LOOPS  = 3,
    parameter int NUM_CH         = 2,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int STRIDE_WIDTH   = 32,
    parameter int NUM_ITER_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    multi_channel_loop_agen_if.master bus
);
    localparam int LVL_W = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1;

    typedef logic [ADDRESS_WIDTH-1:0]  addr_t;
    typedef logic [NUM_ITER_WIDTH-1:0] iter_t;
    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [NUM_LOOPS-1:0]   act_q, act_d, act_in;
    logic [LVL_W-1:0]       inner_q, inner_d, inner_in;
    logic [LOG_NUM_LOOPS-1:0] depth_in;
    iter_t                  max_q  [NUM_LOOPS];
    iter_t                  max_in [NUM_LOOPS];
    addr_t                  stride_q [NUM_CH][NUM_LOOPS];
    iter_t                  iter_q [NUM_LOOPS];
    iter_t                  iter_d [NUM_LOOPS];
    addr_t                  run_q [NUM_CH][NUM_LOOPS];
    addr_t                  run_d [NUM_CH][NUM_LOOPS];
    logic                   last_q, last_d;
    logic                   done_q, done_d;
    logic                   load;

    assign load     = (state_q == IDLE) && bus.start;
    assign depth_in = bus.depth;

    // Effective depth is clamped to 1..NUM_LOOPS; a zero count behaves as one.
    always_comb begin
        int unsigned d;
        iter_t       n;
        d = 32'(depth_in);
        if (d == 0)
            d = 1;
        else if (d > NUM_LOOPS)
            d = NUM_LOOPS;
        inner_in = LVL_W'(d - 1);
        for (int i = 0; i < NUM_LOOPS; i++) begin
            n         = bus.num_iter[i*NUM_ITER_WIDTH +: NUM_ITER_WIDTH];
            act_in[i] = (i < int'(d));
            max_in[i] = (n == '0) ? '0 : n - iter_t'(1);
        end
    end

    // NOTE: configuration registers have no reset; they are only read in RUN,
    // which can only be entered through a load.
    always_ff @(posedge clk) begin
        if (load) begin
            max_q <= max_in;
            for (int c = 0; c < NUM_CH; c++)
                for (int i = 0; i < NUM_LOOPS; i++)
                    stride_q[c][i] <= ADDRESS_WIDTH'($signed(
                        bus.stride[(c*NUM_LOOPS+i)*STRIDE_WIDTH +: STRIDE_WIDTH]));
        end
    end

    // NOTE: combinational blocks use blocking assignments with every output
    // defaulted first, so no path leaves a value unassigned and no latch forms.
    always_comb begin
        int k;
        state_d = state_q;
        act_d   = act_q;
        inner_d = inner_q;
        iter_d  = iter_q;
        run_d   = run_q;
        done_d  = 1'b0;
        k       = 0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    act_d   = act_in;
                    inner_d = inner_in;
                    for (int i = 0; i < NUM_LOOPS; i++) begin
                        iter_d[i] = '0;
                        for (int c = 0; c < NUM_CH; c++)
                            run_d[c][i] = bus.base[c*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (bus.addr_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // Innermost active level that can still advance; deeper ones restart.
                        for (int i = 0; i < NUM_LOOPS; i++)
                            if (act_q[i] && iter_q[i] != max_q[i])
                                k = i;
                        for (int i = 0; i < NUM_LOOPS; i++) begin
                            if (i == k) begin
                                iter_d[i] = iter_q[i] + iter_t'(1);
                                for (int c = 0; c < NUM_CH; c++)
                                    run_d[c][i] = run_q[c][i] + stride_q[c][i];
                            end else if (i > k) begin
                                iter_d[i] = '0;
                                for (int c = 0; c < NUM_CH; c++)
                                    run_d[c][i] = run_q[c][k] + stride_q[c][k];
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        last_d = (state_d == RUN);
        for (int i = 0; i < NUM_LOOPS; i++)
            if (act_d[i] && iter_d[i] != (load ? max_in[i] : max_q[i]))
                last_d = 1'b0;
    end

    // NOTE: the running-address array is reset because addr_out is decoded
    // from it and must read zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            act_q   <= '0;
            inner_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                iter_q[i] <= '0;
                for (int c = 0; c < NUM_CH; c++)
                    run_q[c][i] <= '0;
            end
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            inner_q <= inner_d;
            last_q  <= last_d;
            done_q  <= done_d;
            iter_q  <= iter_d;
            run_q   <= run_d;
        end
    end

    assign bus.addr_valid = (state_q == RUN);
    assign bus.busy       = (state_q == RUN);
    assign bus.addr_last  = last_q;
    assign bus.done       = done_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign bus.addr_out[c*ADDRESS_WIDTH +: ADDRESS_WIDTH] = run_q[c][inner_q];
    end

`ifdef MULTI_CHANNEL_LOOP_AGEN_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_q <= '0;
        else if (load)
            stall_q <= '0;
        else if (state_q == RUN && !bus.addr_ready && stall_q != '1)
            stall_q <= stall_q + 32'd1;
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_multi_channel_loop_agen.sv
// Self-checking bench for multi_channel_loop_agen: tuple-list model built by
// mixed-radix decomposition, a per-cycle compare process, and literal pins.
module tb_multi_channel_loop_agen;
    localparam int NL  = 7;
    localparam int LNL = 4;
    localparam int NC  = 2;
    localparam int AW  = 32;
    localparam int SW  = 32;
    localparam int NIW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_channel_loop_agen_if #(
        .NUM_LOOPS(NL), .LOG_NUM_LOOPS(LNL), .NUM_CH(NC),
        .ADDRESS_WIDTH(AW), .STRIDE_WIDTH(SW), .NUM_ITER_WIDTH(NIW)
    ) bus ();

    multi_channel_loop_agen #(
        .NUM_LOOPS(NL), .LOG_NUM_LOOPS(LNL), .NUM_CH(NC),
        .ADDRESS_WIDTH(AW), .STRIDE_WIDTH(SW), .NUM_ITER_WIDTH(NIW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int unsigned   cfg_depth;
    int unsigned   cfg_niter  [NL];
    logic [AW-1:0] cfg_base   [NC];
    logic [AW-1:0] cfg_stride [NC][NL];

    logic [NC*AW-1:0] next_seq[$];
    logic [NC*AW-1:0] exp_q[$];
    logic [NC*AW-1:0] got_q[$];
    logic             got_last[$];
    bit               running   = 1'b0;
    bit               done_exp  = 1'b0;
    int unsigned      stall_exp = 0;
    int               xfer_cnt  = 0;
    bit [7:0]         ready_pat = 8'h01;
    int               ready_len = 1;

    logic [31:0] basic_c0[6] = '{32'h100, 32'h104, 32'h110, 32'h114, 32'h120, 32'h124};
    logic [31:0] basic_c1[6] = '{32'h0, 32'h40, 32'h1, 32'h41, 32'h2, 32'h42};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tuple t is the mixed-radix number of the active counters, innermost digit fastest.
    task automatic build_model();
        int unsigned   d, total, rem, dig;
        int unsigned   cnt[NL];
        logic [AW-1:0] a[NC];
        d = (cfg_depth == 0) ? 1 : ((cfg_depth > NL) ? NL : cfg_depth);
        total = 1;
        for (int i = 0; i < NL; i++) begin
            cnt[i] = (cfg_niter[i] == 0) ? 1 : cfg_niter[i];
            if (i < int'(d)) total = total * cnt[i];
        end
        next_seq.delete();
        for (int unsigned t = 0; t < total; t++) begin
            rem = t;
            for (int c = 0; c < NC; c++) a[c] = cfg_base[c];
            for (int i = int'(d) - 1; i >= 0; i--) begin
                dig = rem % cnt[i];
                rem = rem / cnt[i];
                for (int c = 0; c < NC; c++) a[c] = a[c] + AW'(dig) * cfg_stride[c][i];
            end
            next_seq.push_back({a[1], a[0]});
        end
    endtask

    task automatic drive_cfg();
        bus.depth = LNL'(cfg_depth);
        for (int i = 0; i < NL; i++) bus.num_iter[i*NIW +: NIW] = NIW'(cfg_niter[i]);
        for (int c = 0; c < NC; c++) begin
            bus.base[c*AW +: AW] = cfg_base[c];
            for (int i = 0; i < NL; i++) bus.stride[(c*NL+i)*SW +: SW] = cfg_stride[c][i];
        end
    endtask

    task automatic start_seq();
        drive_cfg();
        build_model();
        got_q.delete();
        got_last.delete();
        xfer_cnt  = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Returns in the done cycle when chain is set, otherwise one cycle later.
    task automatic finish_seq(input string name, input bit chain);
        int n;
        logic [31:0] stall_req;
        n = 0;
        while (running && n < 300) begin
            tick();
            n++;
        end
        if (running) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: still running after %0d cycles, required done", name, n);
        end
        check({name, "_done"}, bus.done, 1'b1);
        check({name, "_busy"}, bus.busy, 1'b0);
`ifdef MULTI_CHANNEL_LOOP_AGEN_STALL_CNT_EN
        stall_req = stall_exp;
`else
        stall_req = 32'd0;
`endif
        check({name, "_stall_cnt"}, bus.stall_cnt, stall_req);
        if (!chain) tick();
    endtask

    task automatic check_log(input string name, input int n,
                             input logic [31:0] c0[6], input logic [31:0] c1[6]);
        check({name, "_count"}, got_q.size(), n);
        check({name, "_model_count"}, next_seq.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_ch0_%0d", name, i), got_q[i][31:0], c0[i]);
                check($sformatf("%s_ch1_%0d", name, i), got_q[i][63:32], c1[i]);
                check($sformatf("%s_last_%0d", name, i), got_last[i], i == n - 1);
            end
            if (i < next_seq.size()) begin
                check($sformatf("%s_model_ch0_%0d", name, i), next_seq[i][31:0], c0[i]);
                check($sformatf("%s_model_ch1_%0d", name, i), next_seq[i][63:32], c1[i]);
            end
        end
    endtask

    task automatic set_basic();
        cfg_depth     = 2;
        cfg_niter     = '{3, 2, 5, 5, 5, 5, 5};
        cfg_base[0]   = 32'h100;
        cfg_base[1]   = 32'h0;
        cfg_stride[0] = '{32'h10, 32'h4, 32'h999, 32'h999, 32'h999, 32'h999, 32'h999};
        cfg_stride[1] = '{32'h1, 32'h40, 32'h777, 32'h777, 32'h777, 32'h777, 32'h777};
    endtask

    task automatic set_deep(input int unsigned d);
        cfg_depth     = d;
        cfg_niter     = '{2, 1, 1, 1, 1, 1, 2};
        cfg_base[0]   = 32'h0;
        cfg_base[1]   = 32'h0;
        cfg_stride[0] = '{32'h1000, 32'h55, 32'h55, 32'h55, 32'h55, 32'h55, 32'h8};
        cfg_stride[1] = '{32'h1, 32'h33, 32'h33, 32'h33, 32'h33, 32'h33, 32'hFFFF_FFFF};
    endtask

    // Ready pattern is replayed cyclically, changing just after each rising edge.
    initial begin
        int idx;
        idx = 0;
        bus.addr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.addr_ready = ready_pat[idx % ready_len];
            idx++;
        end
    end

    // Compare process: check what the DUT shows now, then advance the model
    // with the inputs the next rising edge will sample.
    always @(negedge clk) begin
        if (reset) begin
            running   = 1'b0;
            done_exp  = 1'b0;
            stall_exp = 0;
            exp_q.delete();
        end else begin
            check("valid", bus.addr_valid, running);
            check("busy", bus.busy, running);
            check("done", bus.done, done_exp);
            if (running) begin
                check("addr_out", bus.addr_out, exp_q[0]);
                check("addr_last", bus.addr_last, exp_q.size() == 1);
            end
            done_exp = 1'b0;
            if (running) begin
                if (!bus.addr_ready) stall_exp++;
                if (bus.abort) begin
                    running  = 1'b0;
                    done_exp = 1'b1;
                    exp_q.delete();
                end else if (bus.addr_ready) begin
                    got_q.push_back(bus.addr_out);
                    got_last.push_back(bus.addr_last);
                    xfer_cnt++;
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        running  = 1'b0;
                        done_exp = 1'b1;
                    end
                end
            end else if (bus.start) begin
                running   = 1'b1;
                exp_q     = next_seq;
                stall_exp = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c0[6];
        logic [31:0] c1[6];
        int n;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.depth      = '0;
        bus.num_iter   = '0;
        bus.base       = '0;
        bus.stride     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr_out", bus.addr_out, 64'h0);
        check("rst_valid", bus.addr_valid, 1'b0);
        check("rst_last", bus.addr_last, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_stall", bus.stall_cnt, 32'h0);
        reset = 1'b0;
        tick();

        // Basic walk, then a back-pressured run started in the done cycle.
        set_basic();
        start_seq();
        check("basic_first", bus.addr_out, {32'h0, 32'h100});
        finish_seq("basic", 1'b1);
        check_log("basic", 6, basic_c0, basic_c1);
        ready_pat = 8'h29;
        ready_len = 6;
        start_seq();
        finish_seq("bp", 1'b0);
        check_log("bp", 6, basic_c0, basic_c1);
        ready_pat = 8'h01;
        ready_len = 1;

        // Depth 0 with a zero count: a single tuple at base.
        cfg_depth     = 0;
        cfg_niter     = '{0, 0, 0, 0, 0, 0, 0};
        cfg_base[0]   = 32'h1234;
        cfg_base[1]   = 32'hFFFF_0000;
        cfg_stride[0] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h10};
        cfg_stride[1] = '{32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20};
        start_seq();
        finish_seq("depth0", 1'b0);
        c0 = '{32'h1234, 0, 0, 0, 0, 0};
        c1 = '{32'hFFFF_0000, 0, 0, 0, 0, 0};
        check_log("depth0", 1, c0, c1);

        // Negative stride wrapping below zero.
        cfg_depth     = 1;
        cfg_niter     = '{3, 4, 4, 4, 4, 4, 4};
        cfg_base[0]   = 32'h4;
        cfg_base[1]   = 32'h10;
        cfg_stride[0] = '{32'hFFFF_FFFC, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1};
        cfg_stride[1] = '{32'h8, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1};
        start_seq();
        finish_seq("wrap", 1'b0);
        c0 = '{32'h4, 32'h0, 32'hFFFF_FFFC, 0, 0, 0};
        c1 = '{32'h10, 32'h18, 32'h20, 0, 0, 0};
        check_log("wrap", 3, c0, c1);

        // Depth above NUM_LOOPS clamps to the full nest.
        c0 = '{32'h0, 32'h8, 32'h1000, 32'h1008, 0, 0};
        c1 = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 0};
        set_deep(9);
        start_seq();
        finish_seq("depth9", 1'b0);
        check_log("depth9", 4, c0, c1);
        set_deep(7);
        start_seq();
        finish_seq("depth7", 1'b0);
        check_log("depth7", 4, c0, c1);

        // Abort after two transfers, then a clean restart from base.
        set_basic();
        start_seq();
        n = 0;
        while (xfer_cnt < 2 && n < 50) begin
            tick();
            n++;
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_valid", bus.addr_valid, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b1);
        check("abort_xfers", got_q.size(), 2);
        tick();
        start_seq();
        check("restart_first", bus.addr_out, {32'h0, 32'h100});
        finish_seq("restart", 1'b0);
        check_log("restart", 6, basic_c0, basic_c1);

        // Reset mid-run: outputs clear at once and no done pulse follows.
        ready_pat = 8'h29;
        ready_len = 6;
        start_seq();
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("mid_rst_addr_out", bus.addr_out, 64'h0);
        check("mid_rst_valid", bus.addr_valid, 1'b0);
        check("mid_rst_last", bus.addr_last, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_done", bus.done, 1'b0);
        check("mid_rst_stall", bus.stall_cnt, 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("post_rst_done", bus.done, 1'b0);

        // A start pulse with different configuration during RUN is ignored.
        start_seq();
        repeat (2) tick();
        cfg_base[0] = 32'hDEAD_0000;
        cfg_depth   = 1;
        drive_cfg();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        finish_seq("ignore", 1'b0);
        check_log("ignore", 6, basic_c0, basic_c1);
        ready_pat = 8'h01;
        ready_len = 1;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
